// File: rtl/magma_if.sv
// magma_if: request/response bundle between the key/data entry driver and the Magma engine.
interface magma_if #(
    parameter int N_BLOCKS = 2
);
    logic                    start;
    logic                    decrypt;
    logic [255:0]            key;
    logic [64*N_BLOCKS-1:0]  data_in;
    logic [64*N_BLOCKS-1:0]  data_out;
    logic                    busy;
    logic                    done;

    modport master (output start, decrypt, key, data_in, input data_out, busy, done);
    modport slave  (input start, decrypt, key, data_in, output data_out, busy, done);
endinterface

// File: rtl/magma_core.sv
// magma_core: iterative GOST R 34.12-2015 Magma ECB engine, one Feistel round per clock.
// Define MAGMA_KEY_LATCH_EN to capture the key at request accept instead of reading it live.
module magma_core #(
    parameter int N_BLOCKS = 2
) (
    input  logic   clk,
    input  logic   reset,
    magma_if.slave io_bus
);
    localparam int DW = 64 * N_BLOCKS;
    localparam int BW = N_BLOCKS > 1 ? $clog2(N_BLOCKS) : 1;
    // pi'_j packed with entry v at bits [4v+3:4v]
    localparam logic [63:0] SBOX [8] = '{
        64'h1F307D8E9B5A264C, 64'hF0DB74E1C5A93286,
        64'h069C471EDAF2853B, 64'hB9E35A076F4D128C,
        64'hC24BE390D618A5F7, 64'h0E34187BAC296FD5,
        64'h73AD0B4FC19652E8, 64'h2BC96AF43850DE71
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t          r_state, w_next;
    logic [DW-1:0]   r_work, r_data_out, w_work;
    logic [31:0]     r_a1, r_a0, w_sum, w_s, w_g, w_kr;
    logic [4:0]      r_round;
    logic [BW-1:0]   r_blk, w_nblk;
    logic [2:0]      w_kidx;
    logic [63:0]     w_nxt;
    logic [255:0]    w_key;
    logic            r_dec, r_done, w_accept, w_last;

`ifdef MAGMA_KEY_LATCH_EN
    logic [255:0] r_key;

    always_ff @(posedge clk) begin
        if (!reset)
            r_key <= '0;
        else if (w_accept)
            r_key <= io_bus.key;
    end

    assign w_key = r_key;
`else
    assign w_key = io_bus.key;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE ? (io_bus.start ? RUN : IDLE) : (w_last ? IDLE : RUN);
    end

    always_comb begin
        w_accept        = r_state == IDLE && io_bus.start;
        io_bus.busy     = r_state == RUN;
        io_bus.done     = r_done;
        io_bus.data_out = r_data_out;
    end

    // Key order: forward for the first 24 (encrypt) or 8 (decrypt) rounds, reversed after.
    always_comb begin
        w_kidx = (r_dec ? r_round < 5'd8 : r_round < 5'd24) ? r_round[2:0] : ~r_round[2:0];
        w_kr   = w_key[{~w_kidx, 5'd0} +: 32];
        w_sum  = r_a0 + w_kr;
        w_s    = '0;
        for (int j = 0; j < 8; j++)
            w_s[4*j +: 4] = SBOX[j][{w_sum[4*j +: 4], 2'b00} +: 4];
        w_g    = {w_s[20:0], w_s[31:21]} ^ r_a1;
        w_last = r_round == 5'd31 && r_blk == BW'(N_BLOCKS - 1);
        w_nblk = r_blk + 1'b1;
        w_work = r_work;
        for (int i = 0; i < N_BLOCKS; i++)
            w_work[64*i +: 64] = BW'(i) == r_blk ? {w_g, r_a0} : r_work[64*i +: 64];
        w_nxt  = 64'(w_work >> {w_nblk, 6'd0});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_work     <= '0;
            r_data_out <= '0;
            r_a1       <= '0;
            r_a0       <= '0;
            r_round    <= '0;
            r_blk      <= '0;
            r_dec      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_work       <= io_bus.data_in;
                r_dec        <= io_bus.decrypt;
                {r_a1, r_a0} <= io_bus.data_in[63:0];
                r_round      <= '0;
                r_blk        <= '0;
            end else if (r_state == RUN) begin
                r_round <= r_round + 5'd1;
                if (r_round != 5'd31) begin
                    {r_a1, r_a0} <= {r_a0, w_g};
                end else begin
                    r_work       <= w_work;
                    r_blk        <= w_nblk;
                    {r_a1, r_a0} <= w_nxt;
                    if (w_last) begin
                        r_data_out <= w_work;
                        r_done     <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_magma_core.sv
// tb_magma_core: directed checks of magma_core with one-block and two-block instances.
module tb_magma_core;
    localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  PT  = 64'hfedcba9876543210;
    localparam logic [63:0]  CT  = 64'h4ee901e5c2d8ca3d;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat;
    int   seen;
    logic [127:0] exp2;

    int sb [8][16] = '{
        '{12, 4, 6, 2, 10, 5, 11, 9, 14, 8, 13, 7, 0, 3, 15, 1},
        '{6, 8, 2, 3, 9, 10, 5, 12, 1, 14, 4, 7, 11, 13, 0, 15},
        '{11, 3, 5, 8, 2, 15, 10, 13, 14, 1, 7, 4, 12, 9, 6, 0},
        '{12, 8, 2, 1, 13, 4, 15, 6, 7, 0, 10, 5, 3, 14, 9, 11},
        '{7, 15, 5, 10, 8, 1, 6, 13, 0, 9, 3, 14, 11, 4, 2, 12},
        '{5, 13, 15, 6, 9, 2, 12, 10, 11, 7, 8, 1, 4, 3, 14, 0},
        '{8, 14, 2, 5, 6, 9, 1, 12, 15, 4, 11, 0, 13, 10, 3, 7},
        '{1, 7, 14, 13, 0, 5, 8, 3, 4, 15, 10, 6, 9, 12, 11, 2}
    };

    always #5 clk = ~clk;

    magma_if #(.N_BLOCKS(1)) mif1 ();
    magma_if #(.N_BLOCKS(2)) mif2 ();

    magma_core #(.N_BLOCKS(1)) u1 (.clk(clk), .reset(reset), .io_bus(mif1));
    magma_core #(.N_BLOCKS(2)) u2 (.clk(clk), .reset(reset), .io_bus(mif2));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_magma(input logic [63:0] blk, input logic [255:0] k, input logic dec);
        logic [31:0] a1, a0, t, s, f;
        int ki;
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int r = 0; r < 32; r++) begin
            ki = (dec ? r < 8 : r < 24) ? r % 8 : 7 - r % 8;
            t  = a0 + k[255 - 32*ki -: 32];
            s  = 32'd0;
            for (int j = 0; j < 8; j++)
                s |= 32'(sb[j][int'((t >> (4*j)) & 32'hF)]) << (4*j);
            f = ((s << 11) | (s >> 21)) ^ a1;
            if (r < 31) begin
                a1 = a0;
                a0 = f;
            end else begin
                a1 = f;
            end
        end
        return {a1, a0};
    endfunction

    task automatic go1(input logic [63:0] din, input logic dec);
        mif1.data_in = din;
        mif1.decrypt = dec;
        mif1.start   = 1'b1;
        @(posedge clk); #1;
        mif1.start   = 1'b0;
    endtask

    task automatic wait1(output int l);
        l = -1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (mif1.done) begin
                l = c;
                break;
            end
        end
    endtask

    // mode 0 plain, 1 start pulse at clk 10, 2 key change at clk 5, 3 reset at clk 20
    task automatic run2(input logic [127:0] din, input logic dec, input int mode, output int l);
        logic [255:0] k0;
        logic [127:0] prev;
        k0   = mif2.key;
        prev = mif2.data_out;
        l    = -1;
        mif2.data_in = din;
        mif2.decrypt = dec;
        mif2.start   = 1'b1;
        @(posedge clk); #1;
        mif2.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (mode == 1 && c == 10) begin
                mif2.start   = 1'b1;
                mif2.data_in = ~din;
                mif2.decrypt = ~dec;
            end
            if (mode == 1 && c == 11) mif2.start = 1'b0;
            if (mode == 2 && c == 5) mif2.key = ~k0;
            if (mode == 3 && c == 20) reset = 1'b0;
            @(posedge clk); #1;
            if (mode == 3 && c == 20) begin
                check("abort_busy", mif2.busy, 0);
                check("abort_dout", mif2.data_out, 0);
                check("abort_done", mif2.done, 0);
                reset = 1'b1;
                l = c;
                break;
            end
            if (mode == 1 && c == 20) check("hold_dout", mif2.data_out, prev);
            if (mif2.done) begin
                l = c;
                break;
            end
        end
        mif2.data_in = din;
        mif2.decrypt = dec;
        mif2.key     = k0;
    endtask

    initial begin
        mif1.start = 1'b1; mif1.decrypt = 1'b0; mif1.key = KEY; mif1.data_in = PT;
        mif2.start = 1'b1; mif2.decrypt = 1'b0; mif2.key = KEY; mif2.data_in = {CT, PT};
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy1", mif1.busy, 0);
        check("rst_done1", mif1.done, 0);
        check("rst_dout1", mif1.data_out, 0);
        check("rst_busy2", mif2.busy, 0);
        check("rst_done2", mif2.done, 0);
        check("rst_dout2", mif2.data_out, 0);
        mif1.start = 1'b0;
        mif2.start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_busy2", mif2.busy, 0);

        go1(PT, 1'b0);
        check("enc1_busy", mif1.busy, 1);
        wait1(lat);
        check("enc1_lat", lat, 32);
        check("enc1_dout", mif1.data_out, CT);
        check("enc1_busy_end", mif1.busy, 0);

        go1(CT, 1'b1);
        check("b2b_done_drop", mif1.done, 0);
        check("b2b_busy", mif1.busy, 1);
        check("b2b_hold", mif1.data_out, CT);
        wait1(lat);
        check("dec1_lat", lat, 32);
        check("dec1_dout", mif1.data_out, PT);

        exp2 = {ref_magma(CT, KEY, 1'b0), CT};
        run2({CT, PT}, 1'b0, 0, lat);
        check("enc2_lat", lat, 64);
        check("enc2_dout", mif2.data_out, exp2);
        @(posedge clk); #1;
        check("enc2_done_pulse", mif2.done, 0);

        run2({CT, PT}, 1'b0, 1, lat);
        check("busy_start_lat", lat, 64);
        check("busy_start_dout", mif2.data_out, exp2);

        run2({CT, PT}, 1'b0, 3, lat);
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (mif2.done) seen++;
        end
        check("abort_nodone", seen, 0);
        run2(exp2, 1'b1, 0, lat);
        check("dec2_lat", lat, 64);
        check("dec2_dout", mif2.data_out, {CT, PT});

`ifdef MAGMA_KEY_LATCH_EN
        run2({CT, PT}, 1'b0, 2, lat);
        check("keylatch_lat", lat, 64);
        check("keylatch_dout", mif2.data_out, exp2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
